// File: rtl/usb_reg_responder.sv
// Host parallel register bus responder: turns host byte cycles into reg strobes.
// Ports: usb_* host pins, reg_* register-block side, proto_err on illegal strobes.
module usb_reg_responder #(
    parameter int pADDR_WIDTH   = 21,
    parameter int pBYTECNT_SIZE = 7
) (
    input  logic                                   usb_clk,
    input  logic                                   reset,
    input  logic [7:0]                             usb_din,
    output logic [7:0]                             usb_dout,
    output logic                                   usb_isout,
    input  logic [pADDR_WIDTH-1:0]                 usb_addr,
    input  logic                                   usb_rdn,
    input  logic                                   usb_wrn,
    input  logic                                   usb_cen,
    output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0]   reg_address,
    output logic [pBYTECNT_SIZE-1:0]               reg_bytecnt,
    output logic [7:0]                             reg_datao,
    input  logic [7:0]                             reg_datai,
    output logic                                   reg_write,
    output logic                                   reg_read,
    output logic                                   reg_addrvalid,
    output logic                                   proto_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_ERROR
    } state_t;

    state_t                   state_q, state_d;
    logic [pADDR_WIDTH-1:0]   addr_r;
    logic [7:0]               din_r;
    logic                     rdn_r, wrn_r, cen_r;
    logic                     saw_cs_q, saw_cs_d;
    logic [7:0]               datao_d;
    logic                     write_d, read_d, perr_d;

    // Pin input stage; the FSM only ever looks at these copies.
    always_ff @(posedge usb_clk or posedge reset) begin
        if (reset) begin
            addr_r <= '0;
            din_r  <= '0;
            rdn_r  <= 1'b1;
            wrn_r  <= 1'b1;
            cen_r  <= 1'b1;
        end else begin
            addr_r <= usb_addr;
            din_r  <= usb_din;
            rdn_r  <= usb_rdn;
            wrn_r  <= usb_wrn;
            cen_r  <= usb_cen;
        end
    end

    assign {reg_address, reg_bytecnt} = addr_r;
    assign usb_dout      = reg_datai;
    // Tristate enable follows the raw pins so the host sees data with no delay.
    assign usb_isout     = ~usb_rdn & usb_wrn;
    assign reg_addrvalid = (state_q == S_WRITE) || (state_q == S_READ);

    always_ff @(posedge usb_clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            saw_cs_q  <= 1'b0;
            reg_datao <= '0;
            reg_write <= 1'b0;
            reg_read  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            saw_cs_q  <= saw_cs_d;
            reg_datao <= datao_d;
            reg_write <= write_d;
            reg_read  <= read_d;
            proto_err <= perr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        saw_cs_d = saw_cs_q;
        datao_d  = reg_datao;
        write_d  = 1'b0;
        read_d   = 1'b0;
        perr_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!rdn_r && !wrn_r) begin
                    state_d = S_ERROR;
                    perr_d  = 1'b1;
                end else if (!rdn_r) begin
                    // Chip select may arrive with or after the read strobe.
                    state_d  = S_READ;
                    saw_cs_d = ~cen_r;
                end else if (!cen_r && !wrn_r) begin
                    state_d = S_WRITE;
                    datao_d = din_r;
                end
            end
            S_WRITE: begin
                if (!rdn_r) begin
                    state_d = S_ERROR;
                    perr_d  = 1'b1;
                end else if (cen_r) begin
                    state_d = S_IDLE;
                    write_d = 1'b1;
                end else begin
                    datao_d = din_r;
                end
            end
            S_READ: begin
                if (!wrn_r) begin
                    state_d  = S_ERROR;
                    perr_d   = 1'b1;
                    saw_cs_d = 1'b0;
                end else if (rdn_r) begin
                    // Pop only once the host has sampled and only if selected.
                    state_d  = S_IDLE;
                    read_d   = saw_cs_q | ~cen_r;
                    saw_cs_d = 1'b0;
                end else if (!cen_r) begin
                    saw_cs_d = 1'b1;
                end
            end
            S_ERROR: begin
                if (rdn_r && wrn_r && cen_r) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_usb_reg_responder.sv
// Self-checking bench for usb_reg_responder.
// Host bus tasks feed an expectation model; a monitor logs observed strobes.
module tb_usb_reg_responder;

    localparam int AW = 21;
    localparam int BW = 7;

    logic          usb_clk = 1'b0;
    logic          reset;
    logic [7:0]    usb_din;
    logic [7:0]    usb_dout;
    logic          usb_isout;
    logic [AW-1:0] usb_addr;
    logic          usb_rdn;
    logic          usb_wrn;
    logic          usb_cen;
    logic [AW-BW-1:0] reg_address;
    logic [BW-1:0] reg_bytecnt;
    logic [7:0]    reg_datao;
    logic [7:0]    reg_datai;
    logic          reg_write;
    logic          reg_read;
    logic          reg_addrvalid;
    logic          proto_err;

    int checks = 0;
    int errors = 0;

    logic          force_en = 1'b0;
    logic [7:0]    force_val = 8'h00;

    logic [AW+7:0] obs_wq[$];
    logic [AW-1:0] obs_rq[$];
    logic [AW+7:0] exp_wq[$];
    logic [AW-1:0] exp_rq[$];
    int            perr_cyc = 0;

    always #5 usb_clk = ~usb_clk;

    usb_reg_responder #(.pADDR_WIDTH(AW), .pBYTECNT_SIZE(BW)) dut (
        .usb_clk(usb_clk),
        .reset(reset),
        .usb_din(usb_din),
        .usb_dout(usb_dout),
        .usb_isout(usb_isout),
        .usb_addr(usb_addr),
        .usb_rdn(usb_rdn),
        .usb_wrn(usb_wrn),
        .usb_cen(usb_cen),
        .reg_address(reg_address),
        .reg_bytecnt(reg_bytecnt),
        .reg_datao(reg_datao),
        .reg_datai(reg_datai),
        .reg_write(reg_write),
        .reg_read(reg_read),
        .reg_addrvalid(reg_addrvalid),
        .proto_err(proto_err)
    );

    function automatic logic [7:0] datafn(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ {3'b000, a[20:16]} ^ 8'h5A;
    endfunction

    // Register file read data, combinational on the presented address.
    always_comb begin
        reg_datai = force_en ? force_val : datafn({reg_address, reg_bytecnt});
    end

    always @(negedge usb_clk) begin
        if (reg_write) obs_wq.push_back({reg_address, reg_bytecnt, reg_datao});
        if (reg_read) obs_rq.push_back({reg_address, reg_bytecnt});
        if (proto_err) perr_cyc++;
    end

    task automatic clear_q();
        obs_wq.delete();
        obs_rq.delete();
        exp_wq.delete();
        exp_rq.delete();
    endtask

    task automatic settle();
        repeat (4) @(negedge usb_clk);
        #1;
    endtask

    // Host write of one byte; addr held two cycles past cen rise.
    task automatic host_write(input logic [AW-1:0] a, input logic [7:0] d,
                              input int hold, input int gap);
        usb_addr = a;
        usb_din  = d;
        usb_cen  = 1'b0;
        usb_wrn  = 1'b0;
        repeat (hold) @(negedge usb_clk);
        usb_wrn = 1'b1;
        usb_cen = 1'b1;
        exp_wq.push_back({a, d});
        repeat (2 + gap) @(negedge usb_clk);
    endtask

    // Host read; samples pin data just before releasing rdn.
    task automatic host_read(input logic [AW-1:0] a, input logic cs,
                             input logic cs_late, input int hold, input int gap,
                             output logic [7:0] sdata, output logic sisout);
        usb_addr = a;
        usb_rdn  = 1'b0;
        if (cs && !cs_late) usb_cen = 1'b0;
        @(negedge usb_clk);
        if (cs) usb_cen = 1'b0;
        repeat (hold - 1) @(negedge usb_clk);
        sdata  = usb_dout;
        sisout = usb_isout;
        usb_rdn = 1'b1;
        usb_cen = 1'b1;
        if (cs) exp_rq.push_back(a);
        repeat (2 + gap) @(negedge usb_clk);
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        usb_addr = '0;
        usb_din  = '0;
        usb_rdn  = 1'b1;
        usb_wrn  = 1'b1;
        usb_cen  = 1'b1;
        repeat (3) @(negedge usb_clk);
        checks++;
        if ({reg_write, reg_read, reg_addrvalid, proto_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes got %b exp 0000",
                     {reg_write, reg_read, reg_addrvalid, proto_err});
        end
        checks++;
        if (reg_datao !== 8'h00) begin
            errors++;
            $display("FAIL reset_datao got %h exp 00", reg_datao);
        end
        checks++;
        if ({reg_address, reg_bytecnt} !== '0) begin
            errors++;
            $display("FAIL reset_addr got %h exp 0", {reg_address, reg_bytecnt});
        end
        checks++;
        if (usb_isout !== 1'b0) begin
            errors++;
            $display("FAIL reset_isout got %b exp 0", usb_isout);
        end
        reset = 1'b0;
        repeat (2) @(negedge usb_clk);
    endtask

    task automatic test_write_basic();
        logic [AW-1:0] a;
        clear_q();
        a = {7'd0, 7'd5, 7'd2};
        host_write(a, 8'hA5, 2, 0);
        settle();
        checks++;
        if (obs_wq.size() !== 1) begin
            errors++;
            $display("FAIL wr_basic_count got %0d exp 1", obs_wq.size());
        end else begin
            checks++;
            if (obs_wq[0] !== {a, 8'hA5}) begin
                errors++;
                $display("FAIL wr_basic_fields got %h exp %h", obs_wq[0], {a, 8'hA5});
            end
        end
    endtask

    task automatic test_read_basic();
        logic [7:0] sd;
        logic si;
        int p0;
        clear_q();
        p0 = perr_cyc;
        force_en  = 1'b1;
        force_val = 8'h3C;
        host_read(21'h00_0281, 1'b1, 1'b0, 3, 0, sd, si);
        settle();
        force_en = 1'b0;
        checks++;
        if (si !== 1'b1 || sd !== 8'h3C) begin
            errors++;
            $display("FAIL rd_basic_pins got %b/%h exp 1/3c", si, sd);
        end
        checks++;
        if (obs_rq.size() !== 1 || perr_cyc != p0) begin
            errors++;
            $display("FAIL rd_basic_count got %0d perr %0d exp 1 perr 0",
                     obs_rq.size(), perr_cyc - p0);
        end
    endtask

    task automatic test_word();
        logic [31:0] w;
        logic [AW+7:0] e;
        clear_q();
        w = 32'h12345678;
        for (int i = 0; i < 4; i++) begin
            host_write({7'd1, 7'd9, 7'(i)}, w[8*i +: 8], 1, 0);
        end
        settle();
        checks++;
        if (obs_wq.size() !== 4) begin
            errors++;
            $display("FAIL word_count got %0d exp 4", obs_wq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                e = {7'd1, 7'd9, 7'(i), w[8*i +: 8]};
                checks++;
                if (obs_wq[i] !== e) begin
                    errors++;
                    $display("FAIL word_byte%0d got %h exp %h", i, obs_wq[i], e);
                end
            end
        end
    endtask

    task automatic test_proto_err();
        int p0;
        clear_q();
        p0 = perr_cyc;
        usb_rdn = 1'b0;
        usb_wrn = 1'b0;
        usb_cen = 1'b0;
        repeat (3) @(negedge usb_clk);
        usb_rdn = 1'b1;
        usb_wrn = 1'b1;
        usb_cen = 1'b1;
        settle();
        checks++;
        if (perr_cyc - p0 != 1 || obs_wq.size() != 0 || obs_rq.size() != 0) begin
            errors++;
            $display("FAIL proto_pulse got perr %0d wr %0d rd %0d exp 1 0 0",
                     perr_cyc - p0, obs_wq.size(), obs_rq.size());
        end
        host_write(21'h1F_0F03, 8'hC3, 2, 0);
        settle();
        checks++;
        if (obs_wq.size() != 1 || obs_wq[0] !== {21'h1F_0F03, 8'hC3}) begin
            errors++;
            $display("FAIL proto_recover got n=%0d exp 1 write", obs_wq.size());
        end
    endtask

    task automatic test_reset_mid_write();
        clear_q();
        usb_addr = 21'h0A_5A5A;
        usb_din  = 8'h99;
        usb_cen  = 1'b0;
        usb_wrn  = 1'b0;
        repeat (3) @(negedge usb_clk);
        checks++;
        if (reg_addrvalid !== 1'b1) begin
            errors++;
            $display("FAIL midwr_valid got %b exp 1", reg_addrvalid);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({reg_write, reg_addrvalid, reg_datao, reg_address, reg_bytecnt} !== '0) begin
            errors++;
            $display("FAIL midwr_reset got wv=%b%b d=%h a=%h exp zeros",
                     reg_write, reg_addrvalid, reg_datao, {reg_address, reg_bytecnt});
        end
        usb_cen = 1'b1;
        usb_wrn = 1'b1;
        @(negedge usb_clk);
        reset = 1'b0;
        settle();
        checks++;
        if (obs_wq.size() != 0) begin
            errors++;
            $display("FAIL midwr_nowrite got %0d exp 0", obs_wq.size());
        end
        exp_wq.delete();
        host_write(21'h0A_5A5B, 8'h66, 1, 0);
        settle();
        checks++;
        if (obs_wq.size() != 1 || obs_wq[0] !== {21'h0A_5A5B, 8'h66}) begin
            errors++;
            $display("FAIL midwr_after got n=%0d exp 1 write", obs_wq.size());
        end
    endtask

    task automatic test_rdn_no_cs();
        logic [7:0] sd;
        logic si;
        int p0;
        clear_q();
        p0 = perr_cyc;
        host_read(21'h00_1234, 1'b0, 1'b0, 3, 0, sd, si);
        settle();
        checks++;
        if (obs_rq.size() != 0 || perr_cyc != p0) begin
            errors++;
            $display("FAIL nocs got rd %0d perr %0d exp 0 0",
                     obs_rq.size(), perr_cyc - p0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] sd;
        logic si;
        clear_q();
        host_write(21'h01_0001, 8'h11, 1, 0);
        host_read(21'h01_0002, 1'b1, 1'b1, 2, 0, sd, si);
        host_write(21'h01_0003, 8'h33, 1, 0);
        host_read(21'h01_0004, 1'b1, 1'b0, 2, 0, sd, si);
        settle();
        checks++;
        if (obs_wq.size() != 2 || obs_rq.size() != 2) begin
            errors++;
            $display("FAIL b2b_count got wr %0d rd %0d exp 2 2",
                     obs_wq.size(), obs_rq.size());
        end else begin
            checks++;
            if (obs_wq[0] !== exp_wq[0] || obs_wq[1] !== exp_wq[1] ||
                obs_rq[0] !== exp_rq[0] || obs_rq[1] !== exp_rq[1]) begin
                errors++;
                $display("FAIL b2b_fields got %h %h %h %h exp %h %h %h %h",
                         obs_wq[0], obs_wq[1], obs_rq[0], obs_rq[1],
                         exp_wq[0], exp_wq[1], exp_rq[0], exp_rq[1]);
            end
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        logic [7:0] sd, ed;
        logic si, cs;
        int p0;
        clear_q();
        p0 = perr_cyc;
        for (int n = 0; n < 40; n++) begin
            a = AW'($urandom);
            if ($urandom_range(1, 0) == 1) begin
                host_write(a, 8'($urandom), $urandom_range(3, 1), $urandom_range(2, 0));
            end else begin
                cs = ($urandom_range(3, 0) != 0);
                ed = datafn(a);
                host_read(a, cs, 1'($urandom), $urandom_range(4, 2),
                          $urandom_range(2, 0), sd, si);
                checks++;
                if (si !== 1'b1 || sd !== ed) begin
                    errors++;
                    $display("FAIL rnd_pins%0d got %b/%h exp 1/%h", n, si, sd, ed);
                end
            end
        end
        settle();
        checks++;
        if (obs_wq.size() != exp_wq.size() || obs_rq.size() != exp_rq.size() ||
            perr_cyc != p0) begin
            errors++;
            $display("FAIL rnd_counts got wr %0d rd %0d perr %0d exp %0d %0d 0",
                     obs_wq.size(), obs_rq.size(), perr_cyc - p0,
                     exp_wq.size(), exp_rq.size());
        end else begin
            for (int i = 0; i < exp_wq.size(); i++) begin
                checks++;
                if (obs_wq[i] !== exp_wq[i]) begin
                    errors++;
                    $display("FAIL rnd_wr%0d got %h exp %h", i, obs_wq[i], exp_wq[i]);
                end
            end
            for (int i = 0; i < exp_rq.size(); i++) begin
                checks++;
                if (obs_rq[i] !== exp_rq[i]) begin
                    errors++;
                    $display("FAIL rnd_rd%0d got %h exp %h", i, obs_rq[i], exp_rq[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_basic();
        test_word();
        test_proto_err();
        test_reset_mid_write();
        test_rdn_no_cs();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
